// File: rtl/risc16_processor.sv
// risc16_processor: single-cycle 16-bit Harvard RISC core with internal
// instruction ROM, data RAM and an 8x16 register file.
// Optional feature macro: RISC16_HALT_INSN_EN turns opcode 1110 into HALT
// and adds the 'halted' output. Without it, 1110 behaves as a NOP.
module risc16_processor #(
    parameter int    IMEM_DEPTH = 16,
    parameter int    DMEM_DEPTH = 8,
    parameter string IMEM_FILE  = "test.prog",
    parameter string DMEM_FILE  = "test.data"
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc_out,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data
`ifdef RISC16_HALT_INSN_EN
    ,
    output logic        halted
`endif
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic [3:0] {
        OP_LD   = 4'h0,
        OP_ST   = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_INV  = 4'h4,
        OP_LSL  = 4'h5,
        OP_LSR  = 4'h6,
        OP_AND  = 4'h7,
        OP_OR   = 4'h8,
        OP_SLT  = 4'h9,
        OP_NOPA = 4'hA,
        OP_BEQ  = 4'hB,
        OP_BNE  = 4'hC,
        OP_JMP  = 4'hD,
        OP_HALT = 4'hE,
        OP_NOPF = 4'hF
    } opcode_t;

    logic [15:0] r_imem [IMEM_DEPTH];
    logic [15:0] r_dmem [DMEM_DEPTH];
    logic [15:0] r_regs [8];
    logic [15:0] r_pc;

    logic [15:0]    w_insn;
    opcode_t        w_op;
    logic [2:0]     w_rs1;
    logic [2:0]     w_rs2;
    logic [2:0]     w_rd;
    logic [15:0]    w_a;
    logic [15:0]    w_b;
    logic [15:0]    w_pcPlus2;
    logic [15:0]    w_brOffset;
    logic [15:0]    w_brTarget;
    logic [DAW-1:0] w_effAddr;
    logic [15:0]    w_result;
    logic [2:0]     w_wbAddr;
    logic           w_regWrite;
    logic           w_memWrite;
    logic           w_halt;
    logic           w_freeze;
    logic [15:0]    w_pcNext;

    // Fetch wraps naturally because only the low word-index bits of the PC are used
    assign w_insn = r_imem[r_pc[IAW:1]];
    assign w_op   = opcode_t'(w_insn[15:12]);
    assign w_rs1  = w_insn[11:9];
    assign w_rs2  = w_insn[8:6];
    assign w_rd   = w_insn[5:3];

    assign w_a = r_regs[w_rs1];
    assign w_b = r_regs[w_rs2];

    assign w_pcPlus2  = r_pc + 16'd2;
    assign w_brOffset = {{9{w_insn[5]}}, w_insn[5:0], 1'b0};
    assign w_brTarget = w_pcPlus2 + w_brOffset;

    // Only the low address bits survive truncation, and those bits of the
    // sign-extended offset are just the low bits of imm6
    assign w_effAddr = w_a[DAW-1:0] + w_insn[DAW-1:0];

    // Decode and execute: result, write-back target, memory write and next PC
    always_comb begin
        w_result   = 16'h0000;
        w_wbAddr   = w_rd;
        w_regWrite = 1'b0;
        w_memWrite = 1'b0;
        w_halt     = 1'b0;
        w_pcNext   = w_pcPlus2;
        case (w_op)
            OP_LD: begin
                w_result   = r_dmem[w_effAddr];
                w_wbAddr   = w_rs2;
                w_regWrite = 1'b1;
            end
            OP_ST: begin
                w_memWrite = 1'b1;
            end
            OP_ADD: begin
                w_result   = w_a + w_b;
                w_regWrite = 1'b1;
            end
            OP_SUB: begin
                w_result   = w_a - w_b;
                w_regWrite = 1'b1;
            end
            OP_INV: begin
                w_result   = ~w_a;
                w_regWrite = 1'b1;
            end
            OP_LSL: begin
                w_result   = w_a << w_b;
                w_regWrite = 1'b1;
            end
            OP_LSR: begin
                w_result   = w_a >> w_b;
                w_regWrite = 1'b1;
            end
            OP_AND: begin
                w_result   = w_a & w_b;
                w_regWrite = 1'b1;
            end
            OP_OR: begin
                w_result   = w_a | w_b;
                w_regWrite = 1'b1;
            end
            OP_SLT: begin
                w_result   = {15'd0, (w_a < w_b)};
                w_regWrite = 1'b1;
            end
            OP_BEQ: begin
                if (w_a == w_b) w_pcNext = w_brTarget;
            end
            OP_BNE: begin
                if (w_a != w_b) w_pcNext = w_brTarget;
            end
            OP_JMP: begin
                w_pcNext = {w_pcPlus2[15:13], w_insn[11:0], 1'b0};
            end
`ifdef RISC16_HALT_INSN_EN
            OP_HALT: begin
                w_halt   = 1'b1;
                w_pcNext = r_pc;
            end
`endif
            default: begin
            end
        endcase
    end

`ifdef RISC16_HALT_INSN_EN
    logic r_halted;

    // Sticky halt flag, set once HALT executes and cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_halt) begin
            r_halted <= 1'b1;
        end
    end

    assign halted   = r_halted;
    assign w_freeze = w_halt | r_halted;
`else
    assign w_freeze = 1'b0;
`endif

    assign pc_out  = r_pc;
    assign wb_en   = w_regWrite & ~reset & ~w_freeze;
    assign wb_addr = wb_en ? w_wbAddr : 3'd0;
    assign wb_data = wb_en ? w_result : 16'h0000;

    // Architectural state: PC and register file, both cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            if (!w_freeze) r_pc <= w_pcNext;
            if (wb_en) r_regs[wb_addr] <= wb_data;
        end
    end

    // Data RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_memWrite && !reset && !w_freeze) begin
            r_dmem[w_effAddr] <= w_b;
        end
    end

endmodule

// File: tb/tb_risc16_processor.sv
// tb_risc16_processor: directed, table-driven bench for risc16_processor.
// Programs are placed in the ROM through the hierarchy while reset is held.
module tb_risc16_processor;

    logic        clk;
    logic        reset;
    logic [15:0] pc_out;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
`ifdef RISC16_HALT_INSN_EN
    logic        halted;
`endif

    int nChecks;
    int nFails;

    typedef struct {
        int          prog;
        logic [15:0] pc;
        logic        wbEn;
        logic [2:0]  wbAddr;
        logic [15:0] wbData;
    } vector_t;

    vector_t     vecQ [$];
    logic [15:0] progs [0:4][0:15];

    risc16_processor #(
        .IMEM_FILE(""),
        .DMEM_FILE("")
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pc_out (pc_out),
        .wb_en  (wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data)
`ifdef RISC16_HALT_INSN_EN
        ,
        .halted (halted)
`endif
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] rType(input logic [3:0] op, input logic [2:0] rs1,
                                          input logic [2:0] rs2, input logic [2:0] rd);
        return {op, rs1, rs2, rd, 3'b000};
    endfunction

    function automatic logic [15:0] iType(input logic [3:0] op, input logic [2:0] rs1,
                                          input logic [2:0] rs2, input logic [5:0] imm);
        return {op, rs1, rs2, imm};
    endfunction

    function automatic logic [15:0] jType(input logic [11:0] jaddr);
        return {4'hD, jaddr};
    endfunction

    task automatic addVec(input int prog, input logic [15:0] pc, input logic en,
                          input logic [2:0] addr, input logic [15:0] data);
        vector_t v;
        v.prog   = prog;
        v.pc     = pc;
        v.wbEn   = en;
        v.wbAddr = addr;
        v.wbData = data;
        vecQ.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: sample point is the falling edge after the active edge
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkRegsZero(input string tag);
        for (int r = 0; r < 8; r++) begin
            checkOutput($sformatf("%s R%0d", tag, r), dut.r_regs[r], 16'h0000);
        end
    endtask

    task automatic resetAndLoad(input int p);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dut.r_imem[i] = progs[p][i];
        end
        repeat (2) applyStimulus();
        checkOutput($sformatf("p%0d reset wb_en", p), 16'(wb_en), 16'h0000);
        checkOutput($sformatf("p%0d reset pc", p), pc_out, 16'h0000);
        checkRegsZero($sformatf("p%0d reset", p));
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int   curProg;
        logic found;

        nChecks = 0;
        nFails  = 0;
        reset   = 1'b1;
        curProg = -1;

        for (int p = 0; p < 5; p++) begin
            for (int w = 0; w < 16; w++) begin
                progs[p][w] = 16'hF000;
            end
        end

        // Program 0: build constants, store M[0]=1 and M[1]=2, then wrap fetch via pc 30->32
        progs[0][0]  = rType(4'h2, 3'd0, 3'd0, 3'd1);
        progs[0][1]  = rType(4'h4, 3'd0, 3'd0, 3'd1);
        progs[0][2]  = rType(4'h3, 3'd0, 3'd1, 3'd2);
        progs[0][3]  = rType(4'h2, 3'd2, 3'd2, 3'd3);
        progs[0][4]  = iType(4'h1, 3'd0, 3'd2, 6'd0);
        progs[0][5]  = iType(4'h1, 3'd0, 3'd3, 6'd1);
        progs[0][6]  = jType(12'd15);
        progs[0][15] = iType(4'hB, 3'd0, 3'd0, 6'd0);
        addVec(0, 16'd0,  1'b1, 3'd1, 16'h0000);
        addVec(0, 16'd2,  1'b1, 3'd1, 16'hFFFF);
        addVec(0, 16'd4,  1'b1, 3'd2, 16'h0001);
        addVec(0, 16'd6,  1'b1, 3'd3, 16'h0002);
        addVec(0, 16'd8,  1'b0, 3'd0, 16'h0000);
        addVec(0, 16'd10, 1'b0, 3'd0, 16'h0000);
        addVec(0, 16'd12, 1'b0, 3'd0, 16'h0000);
        addVec(0, 16'd30, 1'b0, 3'd0, 16'h0000);
        addVec(0, 16'd32, 1'b1, 3'd1, 16'h0000);

        // Program 1: loads and ALU ops with R0=1, R1=2
        progs[1][0] = iType(4'h0, 3'd0, 3'd0, 6'd0);
        progs[1][1] = iType(4'h0, 3'd0, 3'd1, 6'd0);
        progs[1][2] = rType(4'h2, 3'd0, 3'd1, 3'd2);
        progs[1][3] = rType(4'h3, 3'd0, 3'd1, 3'd3);
        progs[1][4] = rType(4'h9, 3'd0, 3'd1, 3'd4);
        progs[1][5] = rType(4'h5, 3'd1, 3'd0, 3'd5);
        progs[1][6] = rType(4'h4, 3'd0, 3'd0, 3'd6);
        progs[1][7] = rType(4'h7, 3'd2, 3'd1, 3'd7);
        addVec(1, 16'd0,  1'b1, 3'd0, 16'h0001);
        addVec(1, 16'd2,  1'b1, 3'd1, 16'h0002);
        addVec(1, 16'd4,  1'b1, 3'd2, 16'h0003);
        addVec(1, 16'd6,  1'b1, 3'd3, 16'hFFFF);
        addVec(1, 16'd8,  1'b1, 3'd4, 16'h0001);
        addVec(1, 16'd10, 1'b1, 3'd5, 16'h0004);
        addVec(1, 16'd12, 1'b1, 3'd6, 16'hFFFE);
        addVec(1, 16'd14, 1'b1, 3'd7, 16'h0002);

        // Program 2: OR, LSR, oversized shift, then ST followed by LD of the same word
        progs[2][0] = iType(4'h0, 3'd0, 3'd0, 6'd0);
        progs[2][1] = iType(4'h0, 3'd0, 3'd1, 6'd0);
        progs[2][2] = rType(4'h8, 3'd0, 3'd1, 3'd2);
        progs[2][3] = rType(4'h6, 3'd1, 3'd0, 3'd3);
        progs[2][4] = rType(4'h4, 3'd0, 3'd0, 3'd4);
        progs[2][5] = rType(4'h5, 3'd4, 3'd4, 3'd5);
        progs[2][6] = iType(4'h1, 3'd0, 3'd2, 6'd2);
        progs[2][7] = iType(4'h0, 3'd0, 3'd7, 6'd2);
        addVec(2, 16'd0,  1'b1, 3'd0, 16'h0001);
        addVec(2, 16'd2,  1'b1, 3'd1, 16'h0002);
        addVec(2, 16'd4,  1'b1, 3'd2, 16'h0003);
        addVec(2, 16'd6,  1'b1, 3'd3, 16'h0001);
        addVec(2, 16'd8,  1'b1, 3'd4, 16'hFFFE);
        addVec(2, 16'd10, 1'b1, 3'd5, 16'h0000);
        addVec(2, 16'd12, 1'b0, 3'd0, 16'h0000);
        addVec(2, 16'd14, 1'b1, 3'd7, 16'h0003);

        // Program 3: branches forward/backward, taken/not taken, and JMP back to 0
        progs[3][0] = iType(4'h0, 3'd0, 3'd1, 6'd0);
        progs[3][1] = iType(4'hC, 3'd0, 3'd0, 6'd3);
        progs[3][2] = iType(4'hB, 3'd0, 3'd0, 6'd4);
        progs[3][3] = iType(4'hB, 3'd0, 3'd0, 6'd2);
        progs[3][6] = jType(12'd0);
        progs[3][7] = iType(4'hC, 3'd0, 3'd1, 6'h3B);
        addVec(3, 16'd0,  1'b1, 3'd1, 16'h0001);
        addVec(3, 16'd2,  1'b0, 3'd0, 16'h0000);
        addVec(3, 16'd4,  1'b0, 3'd0, 16'h0000);
        addVec(3, 16'd14, 1'b0, 3'd0, 16'h0000);
        addVec(3, 16'd6,  1'b0, 3'd0, 16'h0000);
        addVec(3, 16'd12, 1'b0, 3'd0, 16'h0000);
        addVec(3, 16'd0,  1'b1, 3'd1, 16'h0001);

        // Program 4: NOP encodings, opcode 1110 at pc 4
        progs[4][0] = rType(4'h2, 3'd0, 3'd0, 3'd1);
        progs[4][1] = 16'hA008;
        progs[4][2] = 16'hE008;
        addVec(4, 16'd0, 1'b1, 3'd1, 16'h0000);
        addVec(4, 16'd2, 1'b0, 3'd0, 16'h0000);
        addVec(4, 16'd4, 1'b0, 3'd0, 16'h0000);

        foreach (vecQ[i]) begin
            if (vecQ[i].prog != curProg) begin
                resetAndLoad(vecQ[i].prog);
                curProg = vecQ[i].prog;
            end else begin
                applyStimulus();
            end
            checkOutput($sformatf("v%0d pc", i), pc_out, vecQ[i].pc);
            checkOutput($sformatf("v%0d wb_en", i), 16'(wb_en), 16'(vecQ[i].wbEn));
            if (vecQ[i].wbEn) begin
                checkOutput($sformatf("v%0d wb_addr", i), 16'(wb_addr), 16'(vecQ[i].wbAddr));
                checkOutput($sformatf("v%0d wb_data", i), wb_data, vecQ[i].wbData);
            end
        end

        // Opcode 1110 at pc 4: frozen HALT, or a plain NOP
`ifdef RISC16_HALT_INSN_EN
        for (int c = 0; c < 20; c++) begin
            applyStimulus();
            checkOutput($sformatf("halt c%0d pc", c), pc_out, 16'd4);
            checkOutput($sformatf("halt c%0d wb_en", c), 16'(wb_en), 16'h0000);
            checkOutput($sformatf("halt c%0d halted", c), 16'(halted), 16'h0001);
        end
        checkOutput("halt R1 kept", dut.r_regs[1], 16'h0000);
`else
        applyStimulus();
        checkOutput("1110 nop pc", pc_out, 16'd6);
        checkOutput("1110 nop wb_en", 16'(wb_en), 16'h0000);
`endif

        // Reset in the middle of program 2 at pc 10; RAM must keep M[3]=3
        resetAndLoad(2);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (pc_out == 16'd10) found = 1'b1;
            else applyStimulus();
        end
        checkOutput("reach pc 10", 16'(found), 16'h0001);
        checkOutput("pre-reset wb_en", 16'(wb_en), 16'h0001);
        reset = 1'b1;
        #1;
        checkOutput("mid reset wb_en", 16'(wb_en), 16'h0000);
        checkOutput("mid reset wb_data", wb_data, 16'h0000);
        applyStimulus();
        checkOutput("mid reset pc", pc_out, 16'h0000);
        checkRegsZero("mid reset");
        checkOutput("M[3] kept", dut.r_dmem[3], 16'h0003);
        checkOutput("M[0] kept", dut.r_dmem[0], 16'h0001);
`ifdef RISC16_HALT_INSN_EN
        checkOutput("halted cleared", 16'(halted), 16'h0000);
`endif
        reset = 1'b0;
        #1;
        checkOutput("restart wb_data", wb_data, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
